instr_feeder: RTL and testbench

//  Drives the CPU's 19-bit instruction input. Programs are loaded into a

---
 rtl/instr_feeder.sv | 160 ++++++++++++++++
 tb/tb_instr_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Instruction feeder: loads a program into a local buffer, then streams it to the CPU one word per clock.
// Optional macro FEED_JUMP_EN: a JMP word (opcode 5'b01010) redirects the fetch pointer.
module instr_feeder #(
   parameter int                 INSTR_W  = 19,
   parameter int                 DEPTH    = 64,
   parameter int                 ADDR_W   = 6,
   parameter logic [INSTR_W-1:0] NOP_WORD = 19'h7C000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   input  logic               start,
   input  logic               cpu_stall,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  instr_addr,
   output logic               busy,
   output logic               done,
   output logic               load_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // prog_len needs one extra bit so that a completely full buffer is representable
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]    fetch_ptr_q, fetch_ptr_d;
   logic [ADDR_W:0]      prog_len_q, prog_len_d;
   logic [INSTR_W-1:0]   instruction_q, instruction_d;
   logic [ADDR_W-1:0]    instr_addr_q, instr_addr_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 load_err_q, load_err_d;
   logic                 load_ready_q, load_ready_d;

   logic [INSTR_W-1:0]   prog_mem [DEPTH];
   logic                 mem_we;
   logic [ADDR_W:0]      last_idx;
   logic [ADDR_W-1:0]    adv_ptr;
   logic                 go_done;

`ifdef FEED_JUMP_EN
   logic [INSTR_W-1:0]   cur_word;
   logic [ADDR_W:0]      jmp_tgt;
   logic                 is_jmp;
`endif

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      fetch_ptr_d   = fetch_ptr_q;
      prog_len_d    = prog_len_q;
      instruction_d = instruction_q;
      instr_addr_d  = instr_addr_q;
      load_err_d    = load_err_q;
      mem_we        = 1'b0;

      last_idx = prog_len_q - 1'b1;
      adv_ptr  = fetch_ptr_q + 1'b1;
      go_done  = ({1'b0, fetch_ptr_q} >= last_idx);
`ifdef FEED_JUMP_EN
      // The word being decided on is the one at fetch_ptr, even if a stall NOP is currently on the output
      cur_word = prog_mem[fetch_ptr_q];
      jmp_tgt  = {1'b0, cur_word[ADDR_W-1:0]};
      is_jmp   = (cur_word[INSTR_W-1 -: 5] == 5'b01010);
      if (is_jmp) begin
         adv_ptr = cur_word[ADDR_W-1:0];
         go_done = (jmp_tgt >= prog_len_q);
      end
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (prog_len_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d       = RUN;
                  fetch_ptr_d   = '0;
                  instruction_d = prog_mem[0];
                  instr_addr_d  = '0;
               end
            end else if (load_valid) begin
               if (prog_len_q < DEPTH_L) begin
                  mem_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_q + 1'b1;
                  prog_len_d = prog_len_q + 1'b1;
                  state_d    = IDLE;
               end else begin
                  load_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (cpu_stall) begin
               instruction_d = NOP_WORD;
            end else if (go_done) begin
               state_d       = DONE;
               instruction_d = NOP_WORD;
            end else begin
               fetch_ptr_d   = adv_ptr;
               instruction_d = prog_mem[adv_ptr];
               instr_addr_d  = adv_ptr;
            end
         end
         default: begin
            state_d       = IDLE;
            instruction_d = NOP_WORD;
         end
      endcase

      busy_d       = (state_d == RUN);
      done_d       = (state_d == DONE);
      load_ready_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         fetch_ptr_q   <= '0;
         prog_len_q    <= '0;
         instruction_q <= NOP_WORD;
         instr_addr_q  <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         load_err_q    <= 1'b0;
         load_ready_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         fetch_ptr_q   <= fetch_ptr_d;
         prog_len_q    <= prog_len_d;
         instruction_q <= instruction_d;
         instr_addr_q  <= instr_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         load_err_q    <= load_err_d;
         load_ready_q  <= load_ready_d;
      end
   end

   // Buffer contents survive reset; only the write itself is blocked while rst is high
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         prog_mem[wr_ptr_q] <= load_data;
      end
   end

   assign load_ready  = load_ready_q;
   assign instruction = instruction_q;
   assign instr_addr  = instr_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign load_err    = load_err_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: per-cycle vector table plus hand-written load-overflow and jump sequences.
module tb_instr_feeder;

   localparam int INSTR_W = 19;
   localparam int DEPTH   = 64;
   localparam int ADDR_W  = 6;
   localparam logic [INSTR_W-1:0] NOP = 19'h7C000;
   localparam logic [INSTR_W-1:0] WA  = 19'h00111;
   localparam logic [INSTR_W-1:0] WB  = 19'h00222;
   localparam logic [INSTR_W-1:0] WC  = 19'h00333;
   localparam logic [INSTR_W-1:0] WD  = 19'h00444;
   localparam logic [INSTR_W-1:0] WE  = 19'h00555;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               load_valid = 1'b0;
   logic [INSTR_W-1:0] load_data = '0;
   logic               load_ready;
   logic               start = 1'b0;
   logic               cpu_stall = 1'b0;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  instr_addr;
   logic               busy, done, load_err;

   int checks = 0;
   int errors = 0;

   instr_feeder #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .start(start), .cpu_stall(cpu_stall),
      .instruction(instruction), .instr_addr(instr_addr), .busy(busy),
      .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic               rst, lv;
      logic [INSTR_W-1:0] ld;
      logic               st, stl;
      logic [INSTR_W-1:0] e_instr;
      logic [ADDR_W-1:0]  e_addr;
      logic               chk_addr;
      logic               e_busy, e_done, e_lerr, e_lrdy;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mk(input logic r, input logic lv, input logic [INSTR_W-1:0] ld,
                               input logic st, input logic stl,
                               input logic [INSTR_W-1:0] ei, input int ea, input logic ca,
                               input logic eb, input logic ed, input logic ee, input logic er);
      vec_t v;
      v.rst = r; v.lv = lv; v.ld = ld; v.st = st; v.stl = stl;
      v.e_instr = ei; v.e_addr = ADDR_W'(ea); v.chk_addr = ca;
      v.e_busy = eb; v.e_done = ed; v.e_lerr = ee; v.e_lrdy = er;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare after the edge
   task automatic step(input vec_t v, input int idx);
      vec_t e;
      rst = v.rst; load_valid = v.lv; load_data = v.ld; start = v.st; cpu_stall = v.stl;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("instruction", idx, 32'(instruction), 32'(e.e_instr));
      if (e.chk_addr) chk("instr_addr", idx, 32'(instr_addr), 32'(e.e_addr));
      chk("busy", idx, 32'(busy), 32'(e.e_busy));
      chk("done", idx, 32'(done), 32'(e.e_done));
      chk("load_err", idx, 32'(load_err), 32'(e.e_lerr));
      chk("load_ready", idx, 32'(load_ready), 32'(e.e_lrdy));
   endtask

   function automatic logic [INSTR_W-1:0] pword(input int i);
      return {5'b00001, 14'(i * 3 + 5)};
   endfunction

   initial begin
      // T1: load A,B,C and stream
      tbl.push_back(mk(1,0,0 ,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,1,WA,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,1,WB,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,1,WC,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,0,0 ,1,0, WA ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WB ,1,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WC ,2,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));
      // T2: replay from DONE with a two-cycle stall after A
      tbl.push_back(mk(0,0,0 ,1,0, WA ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,1, NOP,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,1, NOP,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WB ,1,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WC ,2,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));
      // T4: reset two cycles into RUN
      tbl.push_back(mk(0,0,0 ,1,0, WA ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WB ,1,1, 1,0,0,0));
      tbl.push_back(mk(1,0,0 ,0,0, NOP,0,1, 0,0,0,1));
      // T5: start with empty program, with a simultaneous load that must be ignored
      tbl.push_back(mk(0,1,WE,1,0, NOP,0,1, 0,1,0,1));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,1, 0,1,0,1));
      tbl.push_back(mk(0,0,0 ,1,0, NOP,0,1, 0,1,0,1));
      // accepted load in DONE returns to IDLE; single-word program
      tbl.push_back(mk(0,1,WD,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,0,0 ,1,0, WD ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));
      // load and start during RUN are ignored
      tbl.push_back(mk(1,0,0 ,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,1,WA,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,1,WB,0,0, NOP,0,1, 0,0,0,1));
      tbl.push_back(mk(0,0,0 ,1,0, WA ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,1,WE,1,0, WB ,1,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));
      tbl.push_back(mk(0,0,0 ,1,0, WA ,0,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, WB ,1,1, 1,0,0,0));
      tbl.push_back(mk(0,0,0 ,0,0, NOP,0,0, 0,1,0,1));

      @(posedge clk); #1;
      foreach (tbl[i]) step(tbl[i], i);

      // T3: overflow the buffer by one word, then stream it all back
      step(mk(1,0,0,0,0, NOP,0,1, 0,0,0,1), 100);
      for (int i = 0; i < DEPTH; i++)
         step(mk(0,1,pword(i),0,0, NOP,0,1, 0,0,0,1), 200 + i);
      step(mk(0,1,19'h01234,0,0, NOP,0,1, 0,0,1,1), 300);
      step(mk(0,0,0,1,0, pword(0),0,1, 1,0,1,0), 301);
      for (int i = 1; i < DEPTH; i++)
         step(mk(0,0,0,0,0, pword(i),i,1, 1,0,1,0), 400 + i);
      step(mk(0,0,0,0,0, NOP,0,0, 0,1,1,1), 500);
      step(mk(1,0,0,0,0, NOP,0,1, 0,0,0,1), 501);

`ifdef FEED_JUMP_EN
      // T6: {X, JMP 0, Y} loops forever between X and JMP
      begin
         logic [INSTR_W-1:0] jw;
         jw = {5'b01010, 14'd0};
         step(mk(0,1,WA,0,0, NOP,0,1, 0,0,0,1), 600);
         step(mk(0,1,jw,0,0, NOP,0,1, 0,0,0,1), 601);
         step(mk(0,1,WC,0,0, NOP,0,1, 0,0,0,1), 602);
         step(mk(0,0,0,1,0, WA,0,1, 1,0,0,0), 603);
         for (int k = 0; k < 4; k++) begin
            step(mk(0,0,0,0,0, jw,1,1, 1,0,0,0), 610 + 2*k);
            step(mk(0,0,0,0,0, WA,0,1, 1,0,0,0), 611 + 2*k);
         end
         step(mk(1,0,0,0,0, NOP,0,1, 0,0,0,1), 620);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
